// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, its instruction memory and the IF/ID register.
// imem_req/imem_ready: a read completes on any cycle where both are 1; req may drop between cycles.
interface fetch_unit_if;
    logic        stall;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] imem_rdata;
    logic        imem_ready;
    logic [15:0] if_instruction;
    logic [15:0] if_pc_plus;
    logic        if_valid;
    logic        halted;

    modport master (
        input  stall, redirect_valid, redirect_pc, imem_rdata, imem_ready,
        output imem_req, imem_addr, if_instruction, if_pc_plus, if_valid, halted
    );

    modport slave (
        output stall, redirect_valid, redirect_pc, imem_rdata, imem_ready,
        input  imem_req, imem_addr, if_instruction, if_pc_plus, if_valid, halted
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, one-entry IF/ID output buffer and FETCH/HALT control.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h0000,
    parameter logic [4:0]  HALT_OPCODE = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus,
    output logic          o_dbg_state
);

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_pc;
    logic [15:0] r_instr;
    logic [15:0] r_pc_plus;
    logic        r_valid;
    logic [15:0] w_pc_inc;
    logic        w_req;
    logic        w_accept;
    logic        w_is_halt;

    assign w_pc_inc  = r_pc + 16'd2;
    assign w_is_halt = (bus.imem_rdata[15:11] == HALT_OPCODE);

    // Only request when the buffer will have room after this edge; a redirect makes any response moot.
    assign w_req    = rst && (r_state == ST_FETCH) && !bus.redirect_valid
                      && (!r_valid || !bus.stall);
    assign w_accept = w_req && bus.imem_ready;

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = ST_FETCH;
        end else if (w_accept && w_is_halt) begin
            w_state_nxt = ST_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc      <= RESET_PC;
            r_valid   <= 1'b0;
            r_instr   <= 16'h0000;
            r_pc_plus <= 16'h0000;
        end else if (bus.redirect_valid) begin
            r_pc    <= {bus.redirect_pc[15:1], 1'b0};
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_instr   <= bus.imem_rdata;
            r_pc_plus <= w_pc_inc;
            r_valid   <= 1'b1;
            r_pc      <= w_pc_inc;
        end else if (r_valid && !bus.stall) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.imem_req       = w_req;
    assign bus.imem_addr      = r_pc;
    assign bus.if_instruction = r_instr;
    assign bus.if_pc_plus     = r_pc_plus;
    assign bus.if_valid       = r_valid;
    assign bus.halted         = (r_state == ST_HALT);
    assign o_dbg_state        = (r_state == ST_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations, then randomized traffic vs a cycle model.
module tb_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [4:0]  HALT_OP  = 5'b00000;

    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC), .HALT_OPCODE(HALT_OP)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    int total = 0;
    int bad   = 0;

    // Memory image: mode 0 is 16'h4000+addr with one HALT word planted at halt_at; mode 1 is addr^salt.
    logic        mem_mode;
    logic [15:0] halt_at;
    logic [15:0] salt;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (mem_mode == 1'b0) return (a == halt_at) ? 16'h0000 : 16'h4000 + a;
        return a ^ salt;
    endfunction

    assign bus.imem_rdata = (mem_mode == 1'b0)
                            ? ((bus.imem_addr == halt_at) ? 16'h0000 : 16'h4000 + bus.imem_addr)
                            : (bus.imem_addr ^ salt);

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what the fetch stage must hold after each edge.
    logic        m_live = 1'b0;
    logic [15:0] m_pc, m_instr, m_pcp;
    logic        m_valid, m_halt;

    always @(posedge clk) begin
        logic [15:0] word;
        logic        wants;
        if (!rst) begin
            m_live  = 1'b1;
            m_pc    = RESET_PC;
            m_halt  = 1'b0;
            m_valid = 1'b0;
            m_instr = 16'h0000;
            m_pcp   = 16'h0000;
        end else if (m_live) begin
            if (bus.redirect_valid) begin
                m_pc    = bus.redirect_pc & 16'hFFFE;
                m_valid = 1'b0;
                m_halt  = 1'b0;
            end else begin
                wants = !m_halt && (!m_valid || !bus.stall);
                if (wants && bus.imem_ready) begin
                    word    = mem_word(m_pc);
                    m_instr = word;
                    m_pcp   = m_pc + 16'd2;
                    m_pc    = m_pcp;
                    m_valid = 1'b1;
                    if (word[15:11] == HALT_OP) m_halt = 1'b1;
                end else if (m_valid && !bus.stall) begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic exp_req;
        if (m_live) begin
            exp_req = rst && !m_halt && !bus.redirect_valid && (!m_valid || !bus.stall);
            check("cyc_req",    16'(bus.imem_req), 16'(exp_req));
            check("cyc_addr",   bus.imem_addr,       m_pc);
            check("cyc_valid",  16'(bus.if_valid),   16'(m_valid));
            check("cyc_halted", 16'(bus.halted),     16'(m_halt));
            check("cyc_dbg",    16'(dbg_state),      16'(m_halt));
            check("cyc_instr",  bus.if_instruction,  m_instr);
            check("cyc_pcp",    bus.if_pc_plus,      m_pcp);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b0;
        bus.stall = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 16'h0000;
        bus.imem_ready = 1'b0;
        mem_mode = 1'b0;
        halt_at = 16'hFFFF;
        salt = 16'h0000;

        repeat (3) step();
        check("rst_req",   16'(bus.imem_req), 16'h0);
        check("rst_valid", 16'(bus.if_valid), 16'h0);
        check("rst_halt",  16'(bus.halted),   16'h0);
        check("rst_instr", bus.if_instruction, 16'h0000);
        check("rst_pcp",   bus.if_pc_plus,     16'h0000);

        // Straight-line fetch from reset
        rst = 1'b1;
        bus.imem_ready = 1'b1;
        #1;
        check("seq_addr0", bus.imem_addr, 16'h0000);
        check("seq_req0",  16'(bus.imem_req), 16'h1);
        step();
        check("seq_addr1", bus.imem_addr, 16'h0002);
        check("seq_pcp1",  bus.if_pc_plus, 16'h0002);
        check("seq_ins1",  bus.if_instruction, 16'h4000);
        check("seq_val1",  16'(bus.if_valid), 16'h1);
        step();
        check("seq_addr2", bus.imem_addr, 16'h0004);
        check("seq_pcp2",  bus.if_pc_plus, 16'h0004);
        step();
        check("seq_pcp3",  bus.if_pc_plus, 16'h0006);
        check("seq_ins3",  bus.if_instruction, 16'h4004);

        // Stall with a full buffer
        bus.stall = 1'b1;
        #1;
        check("stall_req", 16'(bus.imem_req), 16'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_hold_addr", bus.imem_addr, 16'h0006);
            check("stall_hold_pcp",  bus.if_pc_plus, 16'h0006);
            check("stall_hold_val",  16'(bus.if_valid), 16'h1);
        end
        bus.stall = 1'b0;
        #1;
        check("unstall_req", 16'(bus.imem_req), 16'h1);
        step();
        check("unstall_pcp", bus.if_pc_plus, 16'h0008);
        check("unstall_ins", bus.if_instruction, 16'h4006);

        // Redirect beats a same-cycle memory response
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0123;
        #1;
        check("redir_req", 16'(bus.imem_req), 16'h0);
        step();
        bus.redirect_valid = 1'b0;
        check("redir_valid", 16'(bus.if_valid), 16'h0);
        check("redir_addr",  bus.imem_addr, 16'h0122);

        // HALT word at 0010, then speculative halt cancelled by redirect
        halt_at = 16'h0010;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0010;
        step();
        bus.redirect_valid = 1'b0;
        step();
        check("halt_pcp",  bus.if_pc_plus, 16'h0012);
        check("halt_ins",  bus.if_instruction, 16'h0000);
        check("halt_flag", 16'(bus.halted), 16'h1);
        check("halt_req",  16'(bus.imem_req), 16'h0);
        step();
        check("halt_drain", 16'(bus.if_valid), 16'h0);
        check("halt_req2",  16'(bus.imem_req), 16'h0);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0040;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        check("resume_halt", 16'(bus.halted), 16'h0);
        check("resume_addr", bus.imem_addr, 16'h0040);
        check("resume_req",  16'(bus.imem_req), 16'h1);

        // PC wrap at the top of the address space; odd target has its LSB dropped
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'hFFFF;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap_addr0", bus.imem_addr, 16'hFFFE);
        step();
        check("wrap_pcp",  bus.if_pc_plus, 16'h0000);
        check("wrap_addr", bus.imem_addr, 16'h0000);

        // Reset while halted, stalled, with a full buffer
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 16'h0010;
        step();
        bus.redirect_valid = 1'b0;
        step();
        bus.stall = 1'b1;
        #1;
        check("pre_rst_halt",  16'(bus.halted), 16'h1);
        check("pre_rst_valid", 16'(bus.if_valid), 16'h1);
        rst = 1'b0;
        step();
        check("mid_rst_valid", 16'(bus.if_valid), 16'h0);
        check("mid_rst_halt",  16'(bus.halted), 16'h0);
        check("mid_rst_addr",  bus.imem_addr, RESET_PC);
        check("mid_rst_req",   16'(bus.imem_req), 16'h0);
        rst = 1'b1;
        bus.stall = 1'b0;

        // Randomized traffic, checked every cycle by the model
        mem_mode = 1'b1;
        salt = 16'($urandom);
        for (int n = 0; n < 4000; n++) begin
            step();
            bus.stall          = ($urandom_range(0, 99) < 30);
            bus.imem_ready     = ($urandom_range(0, 99) < 70);
            bus.redirect_valid = ($urandom_range(0, 99) < 4);
            bus.redirect_pc    = 16'($urandom);
            rst                = ($urandom_range(0, 199) != 0);
        end
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
